memory: RTL and testbench

MEMORY -- requirements
Module: memory

---
 rtl/memory.sv | 84 ++++++++
 tb/tb_memory.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/memory.sv
// 1024 x 16 single-port, write-first memory with a registered read port and an
// instruction-opcode control decoder. Define MEMORY_ZERO_INIT_EN for zeroed contents at time zero.
module memory (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  addr,
    input  logic [15:0] din,
    input  logic        wea,
    output logic [15:0] douta,
    output logic        ALUSrc,
    output logic        MemtoReg,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        Branch
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

`ifdef MEMORY_ZERO_INIT_EN
    logic [15:0] mem [1024] = '{default: 16'h0000};
`else
    logic [15:0] mem [1024];
`endif

    logic       valid;
    logic [5:0] opcode;

    // Storage shares the reset-qualified process so a write can never happen
    // while reset is low; the array itself is never cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            douta <= 16'h0000;
            valid <= 1'b0;
        end else begin
            valid <= 1'b1;
            if (wea) begin
                mem[addr] <= din;
                douta     <= din;
            end else begin
                douta <= mem[addr];
            end
        end
    end

    assign opcode = douta[15:10];

    always_comb begin
        ALUSrc   = 1'b0;
        MemtoReg = 1'b0;
        RegDst   = 1'b0;
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        Branch   = 1'b0;
        if (valid) begin
            case (opcode)
                OP_RTYPE: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                end
                OP_LW: begin
                    ALUSrc   = 1'b1;
                    MemtoReg = 1'b1;
                    RegWrite = 1'b1;
                    MemRead  = 1'b1;
                end
                OP_SW: begin
                    ALUSrc   = 1'b1;
                    MemWrite = 1'b1;
                end
                OP_BEQ: begin
                    Branch = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_memory.sv
// Randomized self-checking bench for memory: a word-array reference model with
// write-first read prediction and an opcode table for the control outputs.
module tb_memory;

    logic        clk;
    logic        reset;
    logic [9:0]  addr;
    logic [15:0] din;
    logic        wea;
    logic [15:0] douta;
    logic        ALUSrc, MemtoReg, RegDst, RegWrite, MemRead, MemWrite, Branch;

    memory dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .din      (din),
        .wea      (wea),
        .douta    (douta),
        .ALUSrc   (ALUSrc),
        .MemtoReg (MemtoReg),
        .RegDst   (RegDst),
        .RegWrite (RegWrite),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .Branch   (Branch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          check_cnt = 0;
    int          pass_cnt  = 0;
    logic [15:0] ref_mem [1024];
    bit          known   [1024];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        else
            pass_cnt++;
    endtask

    // {ALUSrc, MemtoReg, RegDst, RegWrite, MemRead, MemWrite, Branch}
    function automatic logic [6:0] exp_ctrl(input logic [15:0] word);
        logic [6:0] c;
        c = 7'b0;
        case (word[15:10])
            6'h00: begin c[4] = 1; c[3] = 1; end
            6'h23: begin c[6] = 1; c[5] = 1; c[3] = 1; c[2] = 1; end
            6'h2B: begin c[6] = 1; c[1] = 1; end
            6'h04: c[0] = 1;
            default: c = 7'b0;
        endcase
        return c;
    endfunction

    function automatic logic [6:0] ctrl_now();
        return {ALUSrc, MemtoReg, RegDst, RegWrite, MemRead, MemWrite, Branch};
    endfunction

    // Apply one cycle of stimulus (called just after a rising edge) and check the result.
    task automatic step(input logic [9:0] a, input logic [15:0] d, input logic w, input string tag);
        logic [15:0] exp_q;
        bit          exp_known;
        addr = a;
        din  = d;
        wea  = w;
        @(posedge clk);
        #1;
        if (w) begin
            ref_mem[a] = d;
            known[a]   = 1'b1;
        end
        exp_known = known[a];
        exp_q     = ref_mem[a];
        if (exp_known) begin
            check({tag, "_douta"}, 32'(douta), 32'(exp_q));
            check({tag, "_ctrl"}, 32'(ctrl_now()), 32'(exp_ctrl(exp_q)));
        end
    endtask

    task automatic reset_pulse(input string tag);
        #2 reset = 1'b0;
        #1;
        check({tag, "_rst_douta"}, 32'(douta), 32'h0);
        check({tag, "_rst_ctrl"}, 32'(ctrl_now()), 32'h0);
        reset = 1'b1;
        #1;
        check({tag, "_postrel_ctrl"}, 32'(ctrl_now()), 32'h0);
    endtask

    initial begin
        logic [5:0] op;
        logic [9:0] a;
        logic       w;
        int         sel;

        for (int i = 0; i < 1024; i++) begin
            known[i]   = 1'b0;
            ref_mem[i] = 16'h0000;
        end
`ifdef MEMORY_ZERO_INIT_EN
        for (int i = 0; i < 1024; i++) known[i] = 1'b1;
`endif
        reset = 1'b0;
        addr  = '0;
        din   = '0;
        wea   = 1'b0;
        #1;
        check("por_douta", 32'(douta), 32'h0);
        check("por_ctrl", 32'(ctrl_now()), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("inrst_douta", 32'(douta), 32'h0);
        reset = 1'b1;
        #1;
        check("prefirst_ctrl", 32'(ctrl_now()), 32'h0);

`ifdef MEMORY_ZERO_INIT_EN
        step(10'd0, 16'h0000, 1'b0, "zero_init_rtype");
`else
        step(10'd0, 16'h0000, 1'b1, "first_rtype");
`endif
        step(10'd1, 16'h1000, 1'b1, "wr_beq");
        step(10'd2, 16'h8C00, 1'b1, "wr_lw");
        step(10'd3, 16'hAC00, 1'b1, "wr_sw");
        step(10'd2, 16'h0000, 1'b0, "rd_lw");
        step(10'd3, 16'h0000, 1'b0, "rd_sw");
        step(10'd1, 16'h0000, 1'b0, "rd_beq");
        step(10'd0, 16'h0000, 1'b0, "rd_rtype");
        step(10'd5, 16'hFC00, 1'b1, "wr_op3f");
        step(10'd6, 16'h03FF, 1'b1, "low_bits_ignored");

        reset_pulse("pulse");
        step(10'd2, 16'h0000, 1'b0, "after_pulse_lw");

        // Writes attempted while reset is low must not land.
        reset = 1'b0;
        addr  = 10'd2;
        din   = 16'h0000;
        wea   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("blocked_douta", 32'(douta), 32'h0);
        check("blocked_ctrl", 32'(ctrl_now()), 32'h0);
        reset = 1'b1;
        step(10'd2, 16'h0000, 1'b0, "blocked_readback");

        step(10'd1023, 16'h2C55, 1'b1, "wr_top");
        step(10'd1023, 16'h2C56, 1'b1, "wr_top_again");
        step(10'd1023, 16'h0000, 1'b0, "rd_top");

        for (int n = 0; n < 400; n++) begin
            a   = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 15));
            w   = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 4);
            case (sel)
                0: op = 6'h00;
                1: op = 6'h23;
                2: op = 6'h2B;
                3: op = 6'h04;
                default: op = 6'($urandom_range(0, 63));
            endcase
            step(a, {op, 10'($urandom)}, w, "rand");
            if ($urandom_range(0, 49) == 0) reset_pulse("rand_pulse");
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
